// File: rtl/lr35902_dbg_uart_tx_if.sv
// Byte-write and serial-line signals of the debug UART transmitter.
// master = debug controller / host side, slave = transmitter.
interface lr35902_dbg_uart_tx_if;
  logic [7:0] data;
  logic       wr;
  logic       full;
  logic       empty;
  logic       busy;
  logic       ovf;
  logic       rts;
  logic       tx;

  modport master (
    output data, wr, rts,
    input  full, empty, busy, ovf, tx
  );

  modport slave (
    input  data, wr, rts,
    output full, empty, busy, ovf, tx
  );
endinterface

// File: rtl/lr35902_dbg_uart_tx.sv
// Debug-link 8N1 transmitter: write-to-start-bit 1 cycle when idle, 10*CLK_DIV cycles per frame.
// No write backpressure: writes into a full FIFO are dropped and flagged on sticky ovf; frame starts wait on rts.
module lr35902_dbg_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 2
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  lr35902_dbg_uart_tx_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]      BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               rts_m;
  logic               rts_s;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   cnt;
  logic               ovf_r;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bit_end;

  state_t             state;
  logic [7:0]         shift;
  logic [15:0]        baud;
  logic [2:0]         bit_idx;
  logic               tx_r;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign bit_end = (baud == 16'd0);
  assign push    = bus.wr && !full;
  // Flow control is consulted only where a frame can begin: from IDLE or at the end of a stop bit.
  assign pop     = !empty && rts_s && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      rts_m <= 1'b0;
      rts_s <= 1'b0;
    end else begin
      rts_m <= bus.rts;
      rts_s <= rts_m;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (push) begin
      mem[wptr] <= bus.data;
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.wr && full) begin
        ovf_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= 8'h00;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      tx_r    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (pop) begin
            shift   <= mem[rptr];
            baud    <= BAUD_MAX;
            bit_idx <= 3'd0;
            tx_r    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= BAUD_MAX;
            tx_r  <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= BAUD_MAX;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx_r    <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // Chain straight into the next start bit so back-to-back bytes have no idle gap.
            if (pop) begin
              shift   <= mem[rptr];
              baud    <= BAUD_MAX;
              bit_idx <= 3'd0;
              tx_r    <= 1'b0;
              state   <= START;
            end else begin
              tx_r  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          tx_r  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.busy  = (state != IDLE);
  assign bus.ovf   = ovf_r;
  assign bus.tx    = tx_r;

endmodule

// File: tb/tb_lr35902_dbg_uart_tx.sv
// Bench for the debug UART transmitter: directed scenarios plus random traffic,
// with a line monitor decoding frames against a byte scoreboard.
module tb_lr35902_dbg_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic uart_clk = 1'b0;
  logic reset    = 1'b0;

  lr35902_dbg_uart_tx_if bus();

  lr35902_dbg_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .uart_clk (uart_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 uart_clk = ~uart_clk;

  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [$];
  int frames_started = 0;
  int frames_done    = 0;
  int last_start     = -1;
  int last_end       = -100;
  int last_gap       = -1;
  int last_wr_edge   = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Line monitor: each start bit pops the next expected byte; every sample of the frame is compared.
  initial begin : monitor
    logic [7:0] b;
    logic [9:0] fr;
    int bad;
    bit aborted;
    forever begin
      @(negedge uart_clk);
      if (reset === 1'b1 && bus.tx === 1'b0) begin
        frames_started++;
        last_gap   = cyc - last_end - 1;
        last_start = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", frames_started, 0);
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        fr      = {1'b1, b, 1'b0};
        bad     = 0;
        aborted = 1'b0;
        for (int s = 0; s < FRAME; s++) begin
          if (s > 0) @(negedge uart_clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (bus.tx !== fr[s / CLK_DIV] || bus.busy !== 1'b1) bad++;
        end
        if (!aborted) begin
          check(bad == 0, $sformatf("frame_%02h_bad_samples", b), bad, 0);
          last_end = cyc;
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d frames, required completion", frames_done);
    $fatal(1);
  end

  task automatic write_one(input logic [7:0] d);
    @(negedge uart_clk);
    bus.data     = d;
    bus.wr       = 1'b1;
    last_wr_edge = cyc + 1;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic drive_idle();
    @(negedge uart_clk);
    bus.wr = 1'b0;
  endtask

  task automatic wait_started(input int n, input int budget, input string name);
    int k = 0;
    while (frames_started < n && k < budget) begin
      @(negedge uart_clk);
      k++;
    end
    check(frames_started >= n, name, frames_started, n);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge uart_clk);
      k++;
    end
    check(frames_done >= n, name, frames_done, n);
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 1000) begin
      @(negedge uart_clk);
      k++;
    end
  endtask

  initial begin : stim
    int fs, fd, s, rc, bad, sent, guard;
    bus.data = 8'h00;
    bus.wr   = 1'b0;
    bus.rts  = 1'b0;

    repeat (3) @(negedge uart_clk);
    check({bus.tx, bus.full, bus.empty, bus.busy, bus.ovf} === 5'b10100, "reset_state",
          int'({bus.tx, bus.full, bus.empty, bus.busy, bus.ovf}), 5'b10100);
    reset   = 1'b1;
    bus.rts = 1'b1;
    repeat (4) @(negedge uart_clk);

    // Single byte: 0x55, one-cycle write-to-start latency, idle afterwards.
    fs = frames_started; fd = frames_done;
    write_one(8'h55);
    drive_idle();
    wait_started(fs + 1, 20, "t1_started");
    check(last_start == last_wr_edge + 1, "t1_latency", last_start - last_wr_edge, 1);
    wait_done(fd + 1, FRAME + 10, "t1_done");
    @(negedge uart_clk);
    check(bus.tx === 1'b1 && bus.busy === 1'b0, "t1_idle", int'({bus.tx, bus.busy}), 2);

    // Back-to-back bytes: no gap between frames.
    fs = frames_started; fd = frames_done;
    write_one(8'hA3);
    write_one(8'h0F);
    drive_idle();
    wait_started(fs + 2, 2 * FRAME + 20, "t2_started");
    check(last_gap == 0, "t2_gap", last_gap, 0);
    check(bus.empty === 1'b1, "t2_empty", int'(bus.empty), 1);
    wait_done(fd + 2, FRAME + 10, "t2_done");

    // Fill with rts low, overflow on the fifth write, then drain in order.
    @(negedge uart_clk);
    bus.rts = 1'b0;
    repeat (4) @(negedge uart_clk);
    fs = frames_started; fd = frames_done;
    for (int i = 1; i <= 4; i++) write_one(8'(i));
    drive_idle();
    check(bus.full === 1'b1, "t3_full", int'(bus.full), 1);
    check(bus.ovf === 1'b0, "t3_ovf_clear", int'(bus.ovf), 0);
    write_one(8'h05);
    drive_idle();
    check(bus.ovf === 1'b1, "t3_ovf_set", int'(bus.ovf), 1);
    bad = 0;
    repeat (20) begin
      @(negedge uart_clk);
      if (bus.tx !== 1'b1) bad++;
    end
    check(bad == 0 && frames_started == fs, "t3_hold_tx_high", bad, 0);
    @(negedge uart_clk);
    rc = cyc;
    bus.rts = 1'b1;
    wait_started(fs + 1, 20, "t3_started");
    check(last_start == rc + 3, "t3_rts_latency", last_start - rc, 3);
    wait_done(fd + 4, 4 * FRAME + 20, "t3_drained");
    repeat (2 * FRAME) @(negedge uart_clk);
    check(frames_started == fs + 4 && exp_q.size() == 0, "t3_no_extra", frames_started - fs, 4);

    // rts dropped mid-frame: current frame completes, next waits for rts.
    check(bus.ovf === 1'b1, "t4_ovf_sticky", int'(bus.ovf), 1);
    fs = frames_started; fd = frames_done;
    write_one(8'h81);
    write_one(8'h3C);
    drive_idle();
    wait_started(fs + 1, 20, "t4_started");
    s = last_start;
    wait_cyc(s + 4 * CLK_DIV + 1);
    bus.rts = 1'b0;
    wait_done(fd + 1, FRAME + 10, "t4_first_done");
    repeat (30) @(negedge uart_clk);
    check(frames_started == fs + 1 && bus.busy === 1'b0, "t4_wait_idle", frames_started - fs, 1);
    rc = cyc;
    bus.rts = 1'b1;
    wait_started(fs + 2, 20, "t4_resumed");
    check(last_start == rc + 3, "t4_rts_latency", last_start - rc, 3);
    wait_done(fd + 2, FRAME + 10, "t4_second_done");

    // Reset mid-DATA with bytes still queued.
    fs = frames_started;
    write_one(8'h00);
    write_one(8'h11);
    write_one(8'h22);
    drive_idle();
    wait_started(fs + 1, 20, "t5_started");
    s = last_start;
    wait_cyc(s + 2 * CLK_DIV + 1);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check(bus.tx === 1'b1, "t5_tx_async", int'(bus.tx), 1);
    check({bus.full, bus.empty, bus.busy, bus.ovf} === 4'b0100, "t5_reset_flags",
          int'({bus.full, bus.empty, bus.busy, bus.ovf}), 4'b0100);
    @(negedge uart_clk);
    @(negedge uart_clk);
    reset = 1'b1;
    fs = frames_started; fd = frames_done;
    repeat (60) @(negedge uart_clk);
    check(frames_started == fs, "t5_no_frame_after_reset", frames_started - fs, 0);
    write_one(8'h5A);
    drive_idle();
    wait_started(fs + 1, 20, "t5_new_started");
    wait_done(fd + 1, FRAME + 10, "t5_new_done");

    // Random traffic with rts wandering; writes only when the model has room.
    sent  = 0;
    guard = 0;
    fd    = frames_done;
    while (sent < 40 && guard < 20000) begin
      @(negedge uart_clk);
      guard++;
      if ($urandom_range(0, 99) < 3) bus.rts = ~bus.rts;
      if (exp_q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
        bus.data = 8'($urandom);
        bus.wr   = 1'b1;
        exp_q.push_back(bus.data);
        sent++;
      end else begin
        bus.wr = 1'b0;
      end
    end
    @(negedge uart_clk);
    bus.wr  = 1'b0;
    bus.rts = 1'b1;
    wait_done(fd + 40, 45 * FRAME, "rand_drained");
    check(exp_q.size() == 0, "rand_queue_empty", exp_q.size(), 0);
    check(bus.ovf === 1'b0, "rand_no_ovf", int'(bus.ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
